// File: rtl/ahbl_to_apb_pkg.sv
// Shared AHB-Lite / APB bus encodings and the bridge state type.
package ahbl_to_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB3 master bridge: one APB transfer per AHB transfer,
// AHB data phase stalled until APB completes, PSLVERR mapped to AHB ERROR.
module ahbl_to_apb
  import ahbl_to_apb_pkg::*;
#(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,

  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic               apbm_pready,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pslverr
);

  bridge_state_t state, state_nxt;
  logic          take;

  // Burst/protection/lock attributes carry no meaning for a single-beat bridge.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0]};

  // Only IDLE and ERR2 present hready_resp=1, so only they may take an address.
  assign take = ahbls_hready && ahbls_htrans[1] &&
                ((state == ST_IDLE) || (state == ST_ERR2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    ahbls_hready_resp = 1'b0;
    ahbls_hresp       = HRESP_OKAY;
    apbm_psel         = 1'b0;
    apbm_penable      = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        ahbls_hready_resp = 1'b1;
        if (state == ST_ERR2) ahbls_hresp = HRESP_ERROR;
        state_nxt = ST_IDLE;
        if (take) begin
          if (ahbls_hsize != HSIZE_WORD) state_nxt = ST_ERR1;
          else if (ahbls_hwrite)         state_nxt = ST_WDATA;
          else                           state_nxt = ST_SETUP;
        end
      end
      ST_WDATA: state_nxt = ST_SETUP;
      ST_SETUP: begin
        apbm_psel = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        apbm_psel    = 1'b1;
        apbm_penable = 1'b1;
        if (apbm_pready) state_nxt = apbm_pslverr ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1: begin
        ahbls_hresp = HRESP_ERROR;
        state_nxt   = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data registers; reset clears them so a reset mid-transfer is clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apbm_paddr   <= '0;
      apbm_pwrite  <= 1'b0;
      apbm_pwdata  <= '0;
      ahbls_hrdata <= '0;
    end else begin
      if (take) begin
        apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
        apbm_pwrite <= ahbls_hwrite;
      end
      if (state == ST_WDATA) apbm_pwdata <= ahbls_hwdata;
      if ((state == ST_ACCESS) && apbm_pready && !apbm_pslverr && !apbm_pwrite)
        ahbls_hrdata <= apbm_prdata;
    end
  end

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Randomised bench for ahbl_to_apb against a transaction-level timing model.
module tb_ahbl_to_apb;

  localparam logic [2:0] WORD = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hready_en;
  logic        hready;
  logic        hready_resp;
  logic        hresp;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hrdata;

  always #5 clk = ~clk;

  // Single-slave bus: global HREADY follows this slave unless the bench holds it low.
  assign hready = hready_resp & hready_en;

  ahbl_to_apb dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready      (hready),
    .ahbls_hready_resp (hready_resp),
    .ahbls_hresp       (hresp),
    .ahbls_haddr       (haddr),
    .ahbls_hwrite      (hwrite),
    .ahbls_htrans      (htrans),
    .ahbls_hsize       (hsize),
    .ahbls_hburst      (hburst),
    .ahbls_hprot       (hprot),
    .ahbls_hmastlock   (hmastlock),
    .ahbls_hwdata      (hwdata),
    .ahbls_hrdata      (hrdata),
    .apbm_paddr        (paddr),
    .apbm_psel         (psel),
    .apbm_penable      (penable),
    .apbm_pwrite       (pwrite),
    .apbm_pwdata       (pwdata),
    .apbm_pready       (pready),
    .apbm_prdata       (prdata),
    .apbm_pslverr      (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One AHB transfer, from its address phase to its final data-phase cycle.
  // Expected per-cycle behaviour is derived from transfer type, wait states and error.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                         input int w, input logic e, input logic [31:0] rd,
                         input logic [31:0] wd);
    int   pre, acc_lo, acc_hi, n;
    logic szerr;
    logic x_rdy, x_resp, x_sel, x_en;
    chk("accept_rdy", hready_resp, 1);
    haddr     = addr;
    hwrite    = wr;
    htrans    = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    hsize     = sz;
    hready_en = 1'b1;
    szerr  = (sz != WORD);
    pre    = wr ? 1 : 0;
    acc_lo = pre + 2;
    acc_hi = pre + 2 + w;
    n      = szerr ? 2 : (acc_hi + (e ? 2 : 1));
    if (!szerr && !e && !wr) exp_hrdata = rd;
    pready  = $urandom_range(0, 1);
    pslverr = $urandom_range(0, 1);
    prdata  = $urandom;
    tick();
    for (int i = 1; i <= n; i++) begin
      if (szerr) begin
        x_rdy = (i == 2); x_resp = 1'b1; x_sel = 1'b0; x_en = 1'b0;
      end else begin
        x_sel  = (i >= pre + 1) && (i <= acc_hi);
        x_en   = (i >= acc_lo) && (i <= acc_hi);
        x_rdy  = (i == n);
        x_resp = e && (i > acc_hi);
      end
      chk("hready_resp", hready_resp, x_rdy);
      chk("hresp", hresp, x_resp);
      chk("psel", psel, x_sel);
      chk("penable", penable, x_en);
      if (x_sel) begin
        chk("paddr", paddr, addr[15:0]);
        chk("pwrite", pwrite, wr);
        if (wr) chk("pwdata", pwdata, wd);
      end
      if (i == n) chk("hrdata", hrdata, exp_hrdata);
      if (i < n) begin
        hwdata = (i == 1) ? wd : $urandom;
        htrans = 2'($urandom_range(0, 3));
        haddr  = $urandom;
        hwrite = $urandom_range(0, 1);
        hsize  = 3'($urandom_range(0, 7));
        if (x_en) begin
          pready  = (i == acc_hi);
          pslverr = (i == acc_hi) ? e : 1'($urandom_range(0, 1));
          prdata  = (i == acc_hi) ? rd : $urandom;
        end else begin
          pready  = $urandom_range(0, 1);
          pslverr = $urandom_range(0, 1);
          prdata  = $urandom;
        end
        tick();
      end
    end
  endtask

  // Idle cycles: either no transfer requested or bus HREADY held low.
  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      if ($urandom_range(0, 1)) begin
        htrans    = 2'($urandom_range(0, 1));
        hready_en = 1'b1;
      end else begin
        htrans    = 2'b10;
        hready_en = 1'b0;
      end
      haddr  = $urandom;
      hwrite = $urandom_range(0, 1);
      hsize  = WORD;
      pready = $urandom_range(0, 1);
      tick();
      chk("gap_hready_resp", hready_resp, 1);
      chk("gap_hresp", hresp, 0);
      chk("gap_psel", psel, 0);
      chk("gap_penable", penable, 0);
    end
    hready_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hready_en = 1'b1; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
    hsize = WORD; hburst = '0; hprot = '0; hmastlock = 1'b0; hwdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0; exp_hrdata = '0;
    tick();
    tick();
    chk("rst_hready_resp", hready_resp, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    rst_n = 1'b1;
    gap(1);

    run_txn(32'h4000_0010, 1'b0, WORD, 0, 1'b0, 32'hCAFE_F00D, $urandom);
    gap(1);
    run_txn(32'h4000_0004, 1'b1, WORD, 3, 1'b0, $urandom, 32'h1234_5678);
    gap(1);
    run_txn(32'h4000_0008, 1'b0, WORD, 0, 1'b1, 32'hDEAD_BEEF, $urandom);
    gap(1);
    run_txn(32'h4000_0000, 1'b1, 3'b000, 0, 1'b0, $urandom, $urandom);
    run_txn(32'h4000_0014, 1'b0, WORD, 0, 1'b0, 32'h0BAD_CAFE, $urandom);
    run_txn(32'h4000_0018, 1'b1, WORD, 0, 1'b0, $urandom, 32'hA5A5_5A5A);

    // Reset asserted for one edge while an access is waiting on pready.
    haddr = 32'h4000_0020; hwrite = 1'b0; hsize = WORD; htrans = 2'b10;
    tick();
    htrans = 2'b00; pready = 1'b0;
    tick();
    chk("pre_rst_penable", penable, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_hready_resp", hready_resp, 1);
    chk("midrst_hresp", hresp, 0);
    chk("midrst_hrdata", hrdata, 0);
    exp_hrdata = '0;
    rst_n = 1'b1;
    gap(1);

    for (int t = 0; t < 200; t++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) < 8) ? WORD : 3'($urandom_range(0, 7));
      run_txn($urandom, 1'($urandom_range(0, 1)), sz, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahbl_to_apb.md
Name: ahbl_to_apb

Overview:
AHB-Lite slave to APB3 master bridge. It sits on the CPU's AHB-Lite bus beside the synchronous SRAM slave and hosts the low-bandwidth peripheral region (UART, GPIO, timers, test-bench peripherals). It performs one APB transfer per AHB transfer. It stalls the AHB data phase until APB completes, and converts PSLVERR into a two-cycle AHB ERROR response.

Parameters:
W_HADDR, 32, AHB address width
W_PADDR, 16, APB address width; PADDR = HADDR[W_PADDR-1:0]
W_DATA, 32, data width on both buses

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is synchronous and active-low
ahbls_hready  in  1  bus-wide HREADY (transfer accepted when high)
ahbls_hready_resp  out  1  slave HREADYOUT
ahbls_hresp  out  1  slave HRESP (1 = ERROR)
ahbls_haddr  in  W_HADDR  address
ahbls_hwrite  in  1  write
ahbls_htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ
ahbls_hsize  in  3  size
ahbls_hburst  in  3  ignored
ahbls_hprot  in  4  ignored
ahbls_hmastlock  in  1  ignored
ahbls_hwdata  in  W_DATA  write data
ahbls_hrdata  out  W_DATA  read data, registered
apbm_paddr  out  W_PADDR  APB address
apbm_psel  out  1  select
apbm_penable  out  1  enable
apbm_pwrite  out  1  write
apbm_pwdata  out  W_DATA  write data
apbm_pready  in  1  APB ready
apbm_prdata  in  W_DATA  APB read data
apbm_pslverr  in  1  APB error

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, hready_resp=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. Takes effect on the next edge even mid-transfer; an in-flight APB access is abandoned, and psel/penable are low the cycle after the reset edge.
- Accept: in IDLE, a transfer is accepted when hready && htrans[1]. haddr[W_PADDR-1:0] and hwrite are registered into paddr and pwrite.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE: hready_resp=1, hresp=0. Accepted read goes to SETUP. Accepted write goes to WDATA. Accepted transfer with hsize != 3'b010 goes to ERR1, and no APB access is made.
- WDATA (write only): hready_resp=0. Captures hwdata into pwdata at the end of this cycle, then goes to SETUP.
- SETUP: psel=1, penable=0, hready_resp=0. Goes to ACCESS.
- ACCESS: psel=1, penable=1, hready_resp=0. Stays while !pready.
  - pready && !pslverr: hrdata <= prdata (reads only; hrdata holds its value on writes). Next state IDLE, with hready_resp=1 in the next cycle.
  - pready && pslverr: go to ERR1. hrdata is not updated.
- ERR1: hready_resp=0, hresp=1. Goes to ERR2.
- ERR2: hready_resp=1, hresp=1. Behaves as IDLE for accepting a new transfer; the master may cancel with htrans=IDLE.
- psel/penable drop in the cycle after the completing ACCESS.
- Minimum latency with zero APB wait states, counting data-phase cycles including the final ready cycle: read 3, write 4, size error 2.
- Back-to-back transfers: the next address is presented while hready_resp=1 in IDLE or ERR2 and is accepted in that same cycle. There are no dead cycles beyond those listed.
- htrans IDLE/BUSY, or hready low, in IDLE: no action; state stays IDLE with OKAY.
- paddr and pwrite are stable from SETUP through completion of ACCESS. pwdata is stable from SETUP onward.
- Unaccepted address-phase inputs are ignored in every state other than IDLE and ERR2.

Decomposition:
- Shared bus package holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HSIZE_WORD=3'b010
  - HRESP_OKAY/HRESP_ERROR
  - the bridge state encoding (3-bit, IDLE=0)
- No sub-module. A single FSM plus address/data registers is the natural granularity.

Test Plan:
- Read addr 0x4000_0010, pready=1 immediately, prdata=0xCAFEF00D -> paddr=0x0010; SETUP at T1, ACCESS at T2; hready_resp=1 and hrdata=0xCAFEF00D at T3.
- Write addr 0x4000_0004, hwdata=0x1234_5678, pready low for 3 ACCESS cycles -> pwdata=0x12345678 from SETUP; penable high for 4 cycles; hready_resp returns to 1 seven cycles after the address phase.
- Read with pready=1 and pslverr=1 -> ERR1 (hready_resp=0, hresp=1), then ERR2 (hready_resp=1, hresp=1); hrdata keeps its previous value; psel low during ERR1.
- Byte write (hsize=0) to 0x4000_0000 -> psel never asserts; ERROR response over 2 cycles.
- Read then write issued back-to-back, the write address presented in the read's final ready cycle -> the write is accepted in that cycle; the second APB SETUP follows WDATA with no idle gap.
- rst_n low for one edge during ACCESS with pready=0 -> next cycle psel=0, penable=0, hready_resp=1, hresp=0, hrdata=0.
